// File: rtl/timeset_accel_divider_pkg.sv
// Shared types and elaboration-time helpers for the accelerating timeset strobe generator.
package timeset_accel_divider_pkg;

  typedef enum logic [1:0] {
    RATE_IDLE  = 2'd0,
    RATE_SLOW  = 2'd1,
    RATE_FAST  = 2'd2,
    RATE_TURBO = 2'd3
  } rate_t;

  // Phase increment for a strobe rate; left untruncated so the caller can range-check it.
  function automatic longint unsigned inc_for(input longint unsigned hz,
                                              input longint unsigned sys_hz,
                                              input int width);
    return ((64'd1 << width) * hz) / sys_hz;
  endfunction

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/timeset_accel_divider_if.sv
// Button-side inputs and strobe/rate outputs of the timeset divider.
interface timeset_accel_divider_if;

  logic       i_en;
  logic       i_fast_set;
  logic       o_timeset_stb;
  logic [1:0] o_rate;

  modport master (output i_en, output i_fast_set, input o_timeset_stb, input o_rate);
  modport slave  (input i_en, input i_fast_set, output o_timeset_stb, output o_rate);

endinterface

// File: rtl/timeset_accel_divider_phase_accumulator.sv
// Generic-width phase accumulator; the carry out of acc + inc marks one strobe period.
module timeset_accel_divider_phase_accumulator #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic [ACC_WIDTH-1:0] i_inc,
  output logic                 o_overflow
);

  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH:0]   sum_s;

  assign sum_s      = {1'b0, acc_r} + {1'b0, i_inc};
  assign o_overflow = sum_s[ACC_WIDTH];

  // Accumulator register: clear wins over advance; the wrap keeps only the low bits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_r <= {ACC_WIDTH{1'b0}};
    end else if (i_clear) begin
      acc_r <= {ACC_WIDTH{1'b0}};
    end else if (i_en) begin
      acc_r <= sum_s[ACC_WIDTH-1:0];
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/timeset_accel_divider.sv
// Set-button strobe generator that steps SLOW -> FAST -> TURBO as strobes accumulate.
module timeset_accel_divider
  import timeset_accel_divider_pkg::*;
#(
  parameter int SYS_CLK_HZ   = 50_000_000,
  parameter int ACC_WIDTH    = 32,
  parameter int SLOW_SET_HZ  = 2,
  parameter int FAST_SET_HZ  = 5,
  parameter int TURBO_SET_HZ = 20,
  parameter int FAST_AFTER   = 4,
  parameter int TURBO_AFTER  = 16
) (
  input logic                     i_clk,
  input logic                     i_reset,
  timeset_accel_divider_if.slave  tsd
);

  localparam longint unsigned INC_SLOW_L  = inc_for(64'(SLOW_SET_HZ),  64'(SYS_CLK_HZ), ACC_WIDTH);
  localparam longint unsigned INC_FAST_L  = inc_for(64'(FAST_SET_HZ),  64'(SYS_CLK_HZ), ACC_WIDTH);
  localparam longint unsigned INC_TURBO_L = inc_for(64'(TURBO_SET_HZ), 64'(SYS_CLK_HZ), ACC_WIDTH);
  localparam longint unsigned ACC_RANGE   = 64'd1 << ACC_WIDTH;
  localparam int              CNT_W       = cnt_width(TURBO_AFTER);

  localparam logic [ACC_WIDTH-1:0] INC_SLOW  = INC_SLOW_L[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] INC_FAST  = INC_FAST_L[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] INC_TURBO = INC_TURBO_L[ACC_WIDTH-1:0];
  localparam logic [CNT_W-1:0]     FAST_AT   = CNT_W'(FAST_AFTER);
  localparam logic [CNT_W-1:0]     TURBO_AT  = CNT_W'(TURBO_AFTER);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ZERO  = CNT_W'(0);

  if (ACC_WIDTH < 8 || ACC_WIDTH > 32 || FAST_AFTER < 1 || TURBO_AFTER <= FAST_AFTER ||
      INC_SLOW_L == 64'd0 || INC_SLOW_L >= ACC_RANGE ||
      INC_FAST_L == 64'd0 || INC_FAST_L >= ACC_RANGE ||
      INC_TURBO_L == 64'd0 || INC_TURBO_L >= ACC_RANGE) begin : g_bad_config
    $error("timeset_accel_divider: unusable parameter set");
  end

  rate_t                rate_r, rate_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s, cnt_inc_s;
  logic                 en_q_r;
  logic                 stb_r, stb_s;
  logic                 clear_s, acc_en_s, overflow_s, press_s;
  logic [ACC_WIDTH-1:0] inc_s;

  assign press_s = tsd.i_en & ~en_q_r;

  timeset_accel_divider_phase_accumulator #(.ACC_WIDTH(ACC_WIDTH)) u_acc (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (clear_s),
    .i_en       (acc_en_s),
    .i_inc      (inc_s),
    .o_overflow (overflow_s)
  );

  // Increment follows the registered rate, so a new rate takes effect one cycle after it is entered.
  always_comb begin
    case (rate_r)
      RATE_FAST:  inc_s = INC_FAST;
      RATE_TURBO: inc_s = INC_TURBO;
      default:    inc_s = INC_SLOW;
    endcase
  end

  // Saturating strobe counter increment.
  always_comb begin
    if (cnt_r == TURBO_AT) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
  end

  // Next-state logic: the rate decision uses the count after this cycle's strobe is counted.
  always_comb begin
    rate_s   = rate_r;
    cnt_s    = cnt_r;
    stb_s    = 1'b0;
    clear_s  = 1'b0;
    acc_en_s = 1'b0;
    case (rate_r)
      RATE_IDLE: begin
        clear_s = 1'b1;
        if (press_s) begin
          rate_s = tsd.i_fast_set ? RATE_FAST : RATE_SLOW;
          cnt_s  = CNT_ONE;
          stb_s  = 1'b1;
        end else begin
          cnt_s  = CNT_ZERO;
        end
      end
      RATE_SLOW, RATE_FAST, RATE_TURBO: begin
        if (!tsd.i_en) begin
          rate_s  = RATE_IDLE;
          cnt_s   = CNT_ZERO;
          clear_s = 1'b1;
        end else begin
          acc_en_s = 1'b1;
          if (overflow_s) begin
            stb_s = 1'b1;
            cnt_s = cnt_inc_s;
          end else begin
            cnt_s = cnt_r;
          end
          if (rate_r == RATE_SLOW && (tsd.i_fast_set || cnt_s == FAST_AT)) begin
            rate_s = RATE_FAST;
          end else if (rate_r == RATE_FAST && cnt_s == TURBO_AT) begin
            rate_s = RATE_TURBO;
          end else begin
            rate_s = rate_r;
          end
        end
      end
      default: begin
        rate_s  = RATE_IDLE;
        cnt_s   = CNT_ZERO;
        clear_s = 1'b1;
      end
    endcase
  end

  // State and output registers; en_q starts high so a button held through reset is ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rate_r <= RATE_IDLE;
      cnt_r  <= CNT_ZERO;
      en_q_r <= 1'b1;
      stb_r  <= 1'b0;
    end else begin
      rate_r <= rate_s;
      cnt_r  <= cnt_s;
      en_q_r <= tsd.i_en;
      stb_r  <= stb_s;
    end
  end

  assign tsd.o_timeset_stb = stb_r;
  assign tsd.o_rate        = rate_r;

endmodule

// File: tb/tb_timeset_accel_divider.sv
// Scenario bench: expected strobe gaps/rates are queued per scenario and checked as strobes arrive.
module tb_timeset_accel_divider;

  typedef struct {
    int         gmin;
    int         gmax;
    logic [1:0] rate_after;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  timeset_accel_divider_if tsd();

  timeset_accel_divider #(
    .SYS_CLK_HZ(1000), .ACC_WIDTH(16), .SLOW_SET_HZ(2), .FAST_SET_HZ(5),
    .TURBO_SET_HZ(20), .FAST_AFTER(4), .TURBO_AFTER(8)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .tsd     (tsd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the next strobe; returns its gap, the rate one cycle later and whether the strobe doubled.
  task automatic wait_stb(input int start, input int limit, output int gap, output bit seen,
                          output logic [1:0] rate_after, output bit dbl);
    gap = start; seen = 1'b0; dbl = 1'b0; rate_after = 2'd0;
    while (!seen && gap < limit) begin
      tick();
      gap++;
      if (tsd.o_timeset_stb === 1'b1) seen = 1'b1;
    end
    if (seen) begin
      tick();
      rate_after = tsd.o_rate;
      dbl = (tsd.o_timeset_stb === 1'b1);
    end
  endtask

  task automatic test_reset();
    int stb_cnt = 0;
    int bad_rate = 0;
    rst = 1'b1; tsd.i_en = 1'b1; tsd.i_fast_set = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (tsd.o_timeset_stb !== 1'b0 || tsd.o_rate !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_values stb=%b rate=%0d, need stb=0 rate=0", tsd.o_timeset_stb, tsd.o_rate);
    end
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (tsd.o_timeset_stb !== 1'b0) stb_cnt++;
      if (tsd.o_rate !== 2'd0) bad_rate++;
    end
    tests_run++;
    if (stb_cnt != 0) begin
      tests_failed++;
      $display("FAIL held_through_reset strobes=%0d, need 0", stb_cnt);
    end
    tests_run++;
    if (bad_rate != 0) begin
      tests_failed++;
      $display("FAIL held_through_reset_rate non-idle cycles=%0d, need 0", bad_rate);
    end
  endtask

  task automatic test_slow_fast_turbo();
    int gap, st; bit seen, dbl; logic [1:0] ra; exp_t e;
    tsd.i_en = 1'b0; tick();
    tsd.i_en = 1'b1;
    sb.push_back('{1, 1, 2'd1});     sb.push_back('{501, 501, 2'd1});
    sb.push_back('{500, 501, 2'd1}); sb.push_back('{500, 501, 2'd2});
    sb.push_back('{200, 201, 2'd2}); sb.push_back('{200, 201, 2'd2});
    sb.push_back('{200, 201, 2'd2}); sb.push_back('{200, 201, 2'd3});
    sb.push_back('{50, 51, 2'd3});   sb.push_back('{50, 51, 2'd3});
    st = 0;
    for (int k = 1; sb.size() > 0; k++) begin
      e = sb.pop_front();
      wait_stb(st, e.gmax + 5, gap, seen, ra, dbl);
      tests_run++;
      if (!seen || gap < e.gmin || gap > e.gmax || ra !== e.rate_after || dbl) begin
        tests_failed++;
        $display("FAIL accel_strobe%0d seen=%0b gap=%0d rate=%0d dbl=%0b, need gap %0d..%0d rate %0d",
                 k, seen, gap, ra, dbl, e.gmin, e.gmax, e.rate_after);
      end
      st = 1;
    end
  endtask

  task automatic test_fast_set();
    int gap, st; bit seen, dbl; logic [1:0] ra; exp_t e;
    int bad_rate = 0;
    tsd.i_en = 1'b0; tsd.i_fast_set = 1'b1; tick();
    tsd.i_en = 1'b1;
    sb.push_back('{1, 1, 2'd2}); sb.push_back('{201, 201, 2'd2});
    st = 0;
    for (int k = 1; sb.size() > 0; k++) begin
      e = sb.pop_front();
      wait_stb(st, e.gmax + 5, gap, seen, ra, dbl);
      tests_run++;
      if (!seen || gap < e.gmin || gap > e.gmax || ra !== e.rate_after || dbl) begin
        tests_failed++;
        $display("FAIL fast_press_strobe%0d seen=%0b gap=%0d rate=%0d, need gap %0d..%0d rate %0d",
                 k, seen, gap, ra, e.gmin, e.gmax, e.rate_after);
      end
      st = 1;
    end
    tsd.i_en = 1'b0; tsd.i_fast_set = 1'b0; tick();
    tsd.i_en = 1'b1;
    wait_stb(0, 5, gap, seen, ra, dbl);
    tests_run++;
    if (!seen || gap != 1 || ra !== 2'd1) begin
      tests_failed++;
      $display("FAIL slow_press seen=%0b gap=%0d rate=%0d, need gap 1 rate 1", seen, gap, ra);
    end
    repeat (100) tick();
    tsd.i_fast_set = 1'b1; tick();
    tests_run++;
    if (tsd.o_rate !== 2'd2) begin
      tests_failed++;
      $display("FAIL mid_slow_fast_set rate=%0d, need 2", tsd.o_rate);
    end
    wait_stb(0, 201, gap, seen, ra, dbl);
    tests_run++;
    if (!seen || ra !== 2'd2) begin
      tests_failed++;
      $display("FAIL mid_slow_next_strobe seen=%0b gap=%0d rate=%0d, need strobe within 201 at rate 2", seen, gap, ra);
    end
    tsd.i_fast_set = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tsd.o_rate !== 2'd2) bad_rate++;
    end
    tests_run++;
    if (bad_rate != 0) begin
      tests_failed++;
      $display("FAIL fast_set_release_no_drop off-rate cycles=%0d, need 0", bad_rate);
    end
  endtask

  task automatic test_release();
    int gap, st; bit seen, dbl; logic [1:0] ra; exp_t e;
    int stb_cnt = 0;
    tsd.i_en = 1'b0; tsd.i_fast_set = 1'b0; tick();
    tsd.i_en = 1'b1;
    wait_stb(0, 5, gap, seen, ra, dbl);
    repeat (490) tick();
    tsd.i_en = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (tsd.o_timeset_stb !== 1'b0) stb_cnt++;
    end
    tests_run++;
    if (stb_cnt != 0 || tsd.o_rate !== 2'd0) begin
      tests_failed++;
      $display("FAIL release_before_overflow strobes=%0d rate=%0d, need 0 and 0", stb_cnt, tsd.o_rate);
    end
    tsd.i_en = 1'b1;
    sb.push_back('{1, 1, 2'd1});     sb.push_back('{501, 501, 2'd1});
    sb.push_back('{500, 501, 2'd1}); sb.push_back('{500, 501, 2'd2});
    st = 0;
    for (int k = 1; sb.size() > 0; k++) begin
      e = sb.pop_front();
      wait_stb(st, e.gmax + 5, gap, seen, ra, dbl);
      tests_run++;
      if (!seen || gap < e.gmin || gap > e.gmax || ra !== e.rate_after || dbl) begin
        tests_failed++;
        $display("FAIL repress_strobe%0d seen=%0b gap=%0d rate=%0d, need gap %0d..%0d rate %0d",
                 k, seen, gap, ra, e.gmin, e.gmax, e.rate_after);
      end
      st = 1;
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int stb_cnt = 0;
    int bad_rate = 0;
    while (tsd.o_rate !== 2'd3 && n < 2000) begin
      tick();
      n++;
    end
    tests_run++;
    if (tsd.o_rate !== 2'd3) begin
      tests_failed++;
      $display("FAIL reach_turbo rate=%0d after %0d cycles, need 3", tsd.o_rate, n);
    end
    rst = 1'b1; tick();
    tests_run++;
    if (tsd.o_timeset_stb !== 1'b0 || tsd.o_rate !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_mid stb=%b rate=%0d, need 0 and 0", tsd.o_timeset_stb, tsd.o_rate);
    end
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tsd.o_timeset_stb !== 1'b0) stb_cnt++;
      if (tsd.o_rate !== 2'd0) bad_rate++;
    end
    tests_run++;
    if (stb_cnt != 0 || bad_rate != 0) begin
      tests_failed++;
      $display("FAIL post_reset_held strobes=%0d non-idle=%0d, need 0 and 0", stb_cnt, bad_rate);
    end
  endtask

  task automatic test_turbo_accuracy();
    int n = 0;
    int stb_cnt = 0;
    int dbl_cnt = 0;
    logic prev = 1'b0;
    tsd.i_en = 1'b0; tick();
    tsd.i_en = 1'b1;
    while (tsd.o_rate !== 2'd3 && n < 3000) begin
      tick();
      n++;
    end
    tests_run++;
    if (tsd.o_rate !== 2'd3) begin
      tests_failed++;
      $display("FAIL turbo_entry rate=%0d after %0d cycles, need 3", tsd.o_rate, n);
    end
    // 50000 cycles * 1310 / 65536 = 999.45 strobes
    for (int i = 0; i < 50000; i++) begin
      tick();
      if (tsd.o_timeset_stb === 1'b1) stb_cnt++;
      if (prev && tsd.o_timeset_stb === 1'b1) dbl_cnt++;
      prev = (tsd.o_timeset_stb === 1'b1);
    end
    tests_run++;
    if (stb_cnt < 998 || stb_cnt > 1001) begin
      tests_failed++;
      $display("FAIL turbo_rate strobes=%0d, need 998..1001", stb_cnt);
    end
    tests_run++;
    if (dbl_cnt != 0) begin
      tests_failed++;
      $display("FAIL turbo_no_double consecutive=%0d, need 0", dbl_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_slow_fast_turbo();
    test_fast_set();
    test_release();
    test_reset_mid();
    test_turbo_accuracy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
